// File: rtl/gate_truth_checker.sv
// gate_truth_checker: sweeps a/b through 00,01,10,11, samples y after a settle
// time and compares each sample against a truth table latched at start.
module gate_truth_checker #(
    parameter int SETTLE_CYCLES = 2,
    parameter int PASSES        = 1,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       exp_table,
    input  logic             y,
    output logic             a,
    output logic             b,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [3:0]       fail_mask,
    output logic [CNT_W-1:0] err_count
);
    localparam int CW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
    localparam int SW = PASSES > 1 ? $clog2(PASSES) : 1;

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;
    state_t state, state_next;

    logic [3:0]    exp_q, mask_next;
    logic [1:0]    idx;
    logic [CW-1:0] cnt;
    logic [SW-1:0] sweep;
    logic          miss, last_vec, last_sweep;

    always_comb begin
        miss           = y != exp_q[idx];
        mask_next      = fail_mask;
        mask_next[idx] = fail_mask[idx] | miss;
        last_vec       = idx == 2'd3;
        last_sweep     = sweep == SW'(PASSES - 1);
        state_next     = state;
        case (state)
            IDLE:    state_next = start ? SETTLE : IDLE;
            SETTLE:  state_next = cnt == CW'(SETTLE_CYCLES - 1) ? SAMPLE : SETTLE;
            SAMPLE:  state_next = last_vec && last_sweep ? DONE : SETTLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = state != IDLE;
    assign done = state == DONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            exp_q     <= '0;
            idx       <= '0;
            cnt       <= '0;
            sweep     <= '0;
            a         <= 1'b0;
            b         <= 1'b0;
            pass      <= 1'b0;
            fail_mask <= '0;
            err_count <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: if (start) begin
                    exp_q     <= exp_table;
                    fail_mask <= '0;
                    err_count <= '0;
                    pass      <= 1'b0;
                    idx       <= '0;
                    sweep     <= '0;
                    cnt       <= '0;
                    {a, b}    <= 2'b00;
                end
                SETTLE: cnt <= cnt + 1'b1;
                SAMPLE: begin
                    fail_mask <= mask_next;
                    if (miss && err_count != '1) err_count <= err_count + 1'b1;
                    cnt    <= '0;
                    idx    <= idx + 2'd1;
                    {a, b} <= idx + 2'd1;
                    if (last_vec) sweep <= sweep + 1'b1;
                    // final vector: stimulus parks at 11 and the verdict is taken from the updated mask
                    if (last_vec && last_sweep) begin
                        {a, b} <= 2'b11;
                        pass   <= mask_next == 4'd0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
